pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives stall, flush and bubble controls into the PC register and into the IF/ID, ID/EX and EX/MEM pipeline registers, so the stage registers contain no hazard logic of their own. It resolves four hazard classes with fixed priority: branch mispredict, multi-cycle mul/div busy, load-use, and instruction-memory wait. It also keeps two performance counters.

## Interface
- `REDIRECT_BUBBLES`, default 1: extra cycles of IF/ID flush after a mispredict, covering fetch latency (0–15).
- `MD_TIMEOUT`, default 64: maximum cycles spent in MD_WAIT before the watchdog fires (2–1023).
- `clk` in 1: single pipeline clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_rs1` in 5: source register 1 of the instruction in ID.
- `id_rs2` in 5: source register 2 of the instruction in ID.
- `id_rs1_used` in 1: the ID instruction reads rs1.
- `id_rs2_used` in 1: the ID instruction reads rs2.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_branch_mispredict` in 1: branch resolved in EX disagrees with the prediction.
- `ex_md_start` in 1: a mul/div is issued from EX this cycle.
- `md_done` in 1: the mul/div unit result is valid this cycle.
- `imem_ready` in 1: instruction memory data is valid this cycle.
- `pc_stall` out 1: hold the PC.
- `ifid_stall` out 1: hold the IF/ID register.
- `ifid_flush` out 1: load NOP 32'h00000013 into IF/ID.
- `idex_stall` out 1: hold the ID/EX register.
- `idex_flush` out 1: load a bubble into ID/EX.
- `exmem_flush` out 1: load a bubble into EX/MEM.
- `md_timeout` out 1: one-cycle pulse when the watchdog fires.
- `stall_cycles` out 32: count of cycles with `pc_stall`=1; saturates at 32'hFFFFFFFF.
- `flush_events` out 16: count of accepted mispredicts; wraps.

## Operation
- FSM states: RUN, MD_WAIT, REDIRECT. All control outputs are a combinational decode of the registered state and the current inputs, giving zero-cycle latency.
- Load-use hazard (`lu`) is true when all of the following hold:
  - `ex_mem_read` = 1;
  - `ex_rd` ≠ 0;
  - `id_rs1_used` and `ex_rd` == `id_rs1`, or `id_rs2_used` and `ex_rd` == `id_rs2`.
- In RUN, evaluated in priority order:
  1. `ex_branch_mispredict`: `ifid_flush`=`idex_flush`=1. `flush_events`++. Go to REDIRECT with count = `REDIRECT_BUBBLES`; if that is 0, stay in RUN.
  2. `ex_md_start`: `pc_stall`=`ifid_stall`=`idex_stall`=`exmem_flush`=1. Clear the watchdog and go to MD_WAIT. If `md_done` is also 1 this cycle, no stall is asserted and the FSM stays in RUN.
  3. `lu`: `pc_stall`=`ifid_stall`=1, `idex_flush`=1. Single cycle; no state change.
  4. `!imem_ready`: `pc_stall`=1, `ifid_flush`=1.
  5. Otherwise all outputs are 0.
- In MD_WAIT:
  - While `md_done`=0: `pc_stall`=`ifid_stall`=`idex_stall`=`exmem_flush`=1, and the watchdog increments.
  - On the `md_done`=1 cycle: all stalls are 0 and the FSM goes to RUN.
  - When the watchdog reaches `MD_TIMEOUT`: pulse `md_timeout`, release the stalls and go to RUN.
  - `lu`, `imem_ready` and `ex_branch_mispredict` are ignored; EX is frozen, so a mispredict cannot be valid.
- In REDIRECT:
  - `ifid_flush`=1, `pc_stall`=0.
  - The count decrements each cycle; go to RUN when it reaches 1.
  - A new mispredict reloads the count and increments `flush_events`.
  - `lu` is ignored, since ID holds a NOP.
- `ex_md_start` and `ex_branch_mispredict` are mutually exclusive by construction. If both are 1, mispredict wins.

## Timing
- While `rst`=1:
  - state = RUN, counters = 0;
  - `ifid_flush`=`idex_flush`=`exmem_flush`=1;
  - all stalls = 0, `md_timeout`=0.
- First edge after `rst` deasserts: normal RUN decode.
- Reset asserted mid-MD_WAIT or mid-REDIRECT: immediate return to RUN; no `md_timeout` pulse.
- Load-use costs exactly 1 bubble. Mispredict costs 2 + `REDIRECT_BUBBLES` flushed slots.
- `stall_cycles` updates on the edge following a stalled cycle.

## Structure
- Shared package `pipe_ctrl_pkg` contains:
  - the state enum (RUN, MD_WAIT, REDIRECT);
  - the constant NOP_INSTR = 32'h00000013;
  - the register-index width constant.
- One sub-module, `load_use_detect`: purely combinational, producing `lu`.
- The FSM, watchdog and counters live in the top module.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs1`=5, `id_rs1_used`=1 → exactly 1 cycle with `pc_stall`=`ifid_stall`=`idex_flush`=1. With `ex_rd`=0 → no stall.
- Mispredict, `REDIRECT_BUBBLES`=2: `ifid_flush` is high for 3 consecutive cycles, `idex_flush` for 1, and `flush_events` reads 1.
- Mul/div: `ex_md_start` pulse, then `md_done` 10 cycles later → stalls high for 10 cycles, 0 on the `md_done` cycle, and `stall_cycles`=10.
- Watchdog, `MD_TIMEOUT`=64: `md_done` never asserted → `md_timeout` pulses once, exactly 64 cycles after entering MD_WAIT, then the FSM is back in RUN.
- Priority: mispredict, `lu` and `!imem_ready` in the same cycle → only the mispredict outputs assert; `pc_stall`=0.
- Reset: assert `rst` during MD_WAIT → all three flushes read 1 and the stalls read 0 in the same cycle, before any clock edge; the counters clear.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer state encoding, the NOP encoding and the register-index width.
package pipe_ctrl_pkg;

    localparam int REG_IDX_W = 5;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        RUN,
        MD_WAIT,
        REDIRECT
    } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags when ID needs the register that the load in EX is about to write.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    output logic                 lu
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_used && (ex_rd == id_rs1);
    assign rs2_hit = id_rs2_used && (ex_rd == id_rs2);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign lu = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard and sequencing controller for the 5-stage pipeline.
// Outputs are a combinational decode of the registered state and the current inputs.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 1,
    parameter int MD_TIMEOUT       = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_used,
    input  logic                 id_rs2_used,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_mispredict,
    input  logic                 ex_md_start,
    input  logic                 md_done,
    input  logic                 imem_ready,
    output logic                 pc_stall,
    output logic                 ifid_stall,
    output logic                 ifid_flush,
    output logic                 idex_stall,
    output logic                 idex_flush,
    output logic                 exmem_flush,
    output logic                 md_timeout,
    output logic [31:0]          stall_cycles,
    output logic [15:0]          flush_events
);

    localparam logic [3:0] REDIR_LOAD = 4'(REDIRECT_BUBBLES);
    localparam logic [9:0] WD_LIMIT   = 10'(MD_TIMEOUT);

    ctrl_state_e state;
    ctrl_state_e next_state;
    logic [3:0]  redir_cnt;
    logic [3:0]  next_redir_cnt;
    logic [9:0]  watchdog;
    logic        wd_clear;
    logic        wd_inc;
    logic        accept_misp;
    logic        lu;

    load_use_detect u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rs1_used (id_rs1_used),
        .id_rs2_used (id_rs2_used),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu          (lu)
    );

    always_comb begin
        pc_stall       = 1'b0;
        ifid_stall     = 1'b0;
        ifid_flush     = 1'b0;
        idex_stall     = 1'b0;
        idex_flush     = 1'b0;
        exmem_flush    = 1'b0;
        md_timeout     = 1'b0;
        next_state     = state;
        next_redir_cnt = redir_cnt;
        wd_clear       = 1'b0;
        wd_inc         = 1'b0;
        accept_misp    = 1'b0;

        // During reset every stage register is loaded with a bubble
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (ex_branch_mispredict) begin
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        accept_misp = 1'b1;
                        if (REDIR_LOAD != 4'd0) begin
                            next_state     = REDIRECT;
                            next_redir_cnt = REDIR_LOAD;
                        end
                    end else if (ex_md_start) begin
                        if (!md_done) begin
                            pc_stall    = 1'b1;
                            ifid_stall  = 1'b1;
                            idex_stall  = 1'b1;
                            exmem_flush = 1'b1;
                            wd_clear    = 1'b1;
                            next_state  = MD_WAIT;
                        end
                    end else if (lu) begin
                        pc_stall   = 1'b1;
                        ifid_stall = 1'b1;
                        idex_flush = 1'b1;
                    end else if (!imem_ready) begin
                        pc_stall   = 1'b1;
                        ifid_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        next_state = RUN;
                    end else if (watchdog == WD_LIMIT) begin
                        md_timeout = 1'b1;
                        next_state = RUN;
                    end else begin
                        pc_stall    = 1'b1;
                        ifid_stall  = 1'b1;
                        idex_stall  = 1'b1;
                        exmem_flush = 1'b1;
                        wd_inc      = 1'b1;
                    end
                end
                REDIRECT: begin
                    ifid_flush = 1'b1;
                    if (ex_branch_mispredict) begin
                        idex_flush     = 1'b1;
                        accept_misp    = 1'b1;
                        next_redir_cnt = REDIR_LOAD;
                    end else if (redir_cnt <= 4'd1) begin
                        next_state = RUN;
                    end else begin
                        next_redir_cnt = redir_cnt - 4'd1;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    // State, watchdog and the two performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            redir_cnt    <= 4'd0;
            watchdog     <= 10'd0;
            stall_cycles <= 32'd0;
            flush_events <= 16'd0;
        end else begin
            state     <= next_state;
            redir_cnt <= next_redir_cnt;
            if (wd_clear) begin
                watchdog <= 10'd0;
            end else if (wd_inc) begin
                watchdog <= watchdog + 10'd1;
            end
            if (pc_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (accept_misp) begin
                flush_events <= flush_events + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

    // Control vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, md_timeout}
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_RESET = 7'b0010110;
    localparam logic [6:0] C_LU    = 7'b1100100;
    localparam logic [6:0] C_IMEM  = 7'b1010000;
    localparam logic [6:0] C_MISP  = 7'b0010100;
    localparam logic [6:0] C_REDIR = 7'b0010000;
    localparam logic [6:0] C_MD    = 7'b1101010;
    localparam logic [6:0] C_TO    = 7'b0000001;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
        logic [4:0] rd;
        logic       mem_read;
        logic       misp;
        logic       md_start;
        logic       md_done;
        logic       imem_ready;
    } stim_t;

    typedef struct packed {
        logic [6:0]  ctl;
        logic        chk;
        logic [31:0] sc;
        logic [15:0] fe;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_branch_mispredict;
    logic        ex_md_start;
    logic        md_done;
    logic        imem_ready;
    logic        pc_stall;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_stall;
    logic        idex_flush;
    logic        exmem_flush;
    logic        md_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_events;

    exp_t  expQ[$];
    string nameQ[$];
    int    vectors;
    int    miscompares;

    pipeline_ctrl #(
        .REDIRECT_BUBBLES (2),
        .MD_TIMEOUT       (64)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .id_rs1               (id_rs1),
        .id_rs2               (id_rs2),
        .id_rs1_used          (id_rs1_used),
        .id_rs2_used          (id_rs2_used),
        .ex_rd                (ex_rd),
        .ex_mem_read          (ex_mem_read),
        .ex_branch_mispredict (ex_branch_mispredict),
        .ex_md_start          (ex_md_start),
        .md_done              (md_done),
        .imem_ready           (imem_ready),
        .pc_stall             (pc_stall),
        .ifid_stall           (ifid_stall),
        .ifid_flush           (ifid_flush),
        .idex_stall           (idex_stall),
        .idex_flush           (idex_flush),
        .exmem_flush          (exmem_flush),
        .md_timeout           (md_timeout),
        .stall_cycles         (stall_cycles),
        .flush_events         (flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.imem_ready = 1'b1;
        return s;
    endfunction

    function automatic exp_t mk(logic [6:0] ctl, logic chk, logic [31:0] sc, logic [15:0] fe);
        exp_t e;
        e.ctl = ctl;
        e.chk = chk;
        e.sc  = sc;
        e.fe  = fe;
        return e;
    endfunction

    task automatic applyStimulus(input stim_t s, input exp_t e, input string name);
        @(posedge clk);
        #1;
        rst                  = s.rst;
        id_rs1               = s.rs1;
        id_rs2               = s.rs2;
        id_rs1_used          = s.rs1_used;
        id_rs2_used          = s.rs2_used;
        ex_rd                = s.rd;
        ex_mem_read          = s.mem_read;
        ex_branch_mispredict = s.misp;
        ex_md_start          = s.md_start;
        md_done              = s.md_done;
        imem_ready           = s.imem_ready;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        logic [6:0] act;
        act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, md_timeout};
        vectors++;
        if (act !== e.ctl) begin
            miscompares++;
            $display("[TB] FAIL %s ctl got %b want %b", name, act, e.ctl);
        end
        if (e.chk) begin
            vectors++;
            if (stall_cycles !== e.sc) begin
                miscompares++;
                $display("[TB] FAIL %s stall_cycles got %0d want %0d", name, stall_cycles, e.sc);
            end
            vectors++;
            if (flush_events !== e.fe) begin
                miscompares++;
                $display("[TB] FAIL %s flush_events got %0d want %0d", name, flush_events, e.fe);
            end
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front(), nameQ.pop_front());
        end
    end

    initial begin
        stim_t s;
        vectors     = 0;
        miscompares = 0;
        s = idle();
        s.rst = 1'b1;
        rst = 1'b1;
        {id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd} = '0;
        {ex_mem_read, ex_branch_mispredict, ex_md_start, md_done} = '0;
        imem_ready = 1'b1;

        applyStimulus(s, mk(C_RESET, 1, 0, 0), "reset");
        s = idle();
        applyStimulus(s, mk(C_NONE, 1, 0, 0), "first_run");

        // Load-use detection
        s = idle(); s.mem_read = 1; s.rd = 5; s.rs1 = 5; s.rs1_used = 1;
        applyStimulus(s, mk(C_LU, 1, 0, 0), "lu_rs1");
        s = idle();
        applyStimulus(s, mk(C_NONE, 1, 1, 0), "lu_one_bubble");
        s = idle(); s.mem_read = 1; s.rd = 0; s.rs1 = 0; s.rs1_used = 1;
        applyStimulus(s, mk(C_NONE, 1, 1, 0), "lu_x0");
        s = idle(); s.mem_read = 1; s.rd = 7; s.rs1 = 7; s.rs2 = 7; s.rs2_used = 1;
        applyStimulus(s, mk(C_LU, 0, 0, 0), "lu_rs2");
        s = idle(); s.mem_read = 1; s.rd = 7; s.rs2 = 7;
        applyStimulus(s, mk(C_NONE, 1, 2, 0), "lu_unused");
        s = idle(); s.rd = 7; s.rs1 = 7; s.rs1_used = 1;
        applyStimulus(s, mk(C_NONE, 0, 0, 0), "lu_no_load");

        s = idle(); s.imem_ready = 0;
        applyStimulus(s, mk(C_IMEM, 1, 2, 0), "imem_wait");
        s = idle();
        applyStimulus(s, mk(C_NONE, 1, 3, 0), "imem_done");

        // Mispredict with two redirect bubbles
        s = idle(); s.misp = 1;
        applyStimulus(s, mk(C_MISP, 1, 3, 0), "misp");
        s = idle();
        applyStimulus(s, mk(C_REDIR, 1, 3, 1), "redir_1");
        applyStimulus(s, mk(C_REDIR, 0, 0, 0), "redir_2");
        applyStimulus(s, mk(C_NONE, 1, 3, 1), "redir_done");

        // Mispredict beats load-use and imem wait; lu ignored in REDIRECT; re-mispredict reloads
        s = idle(); s.misp = 1; s.mem_read = 1; s.rd = 3; s.rs1 = 3; s.rs1_used = 1; s.imem_ready = 0;
        applyStimulus(s, mk(C_MISP, 1, 3, 1), "prio_misp");
        s.misp = 0;
        applyStimulus(s, mk(C_REDIR, 1, 3, 2), "redir_lu_ign");
        s = idle(); s.misp = 1;
        applyStimulus(s, mk(C_MISP, 1, 3, 2), "redir_remisp");
        s = idle();
        applyStimulus(s, mk(C_REDIR, 1, 3, 3), "reload_1");
        applyStimulus(s, mk(C_REDIR, 0, 0, 0), "reload_2");
        applyStimulus(s, mk(C_NONE, 1, 3, 3), "reload_done");

        // Mul/div completing ten cycles after start
        s = idle(); s.md_start = 1;
        applyStimulus(s, mk(C_MD, 1, 3, 3), "md_start");
        for (int i = 0; i < 9; i++) begin
            s = idle();
            if (i == 1) begin
                s.mem_read = 1; s.rd = 4; s.rs1 = 4; s.rs1_used = 1;
            end
            if (i == 2) s.imem_ready = 0;
            applyStimulus(s, mk(C_MD, 0, 0, 0), "md_wait");
        end
        s = idle(); s.md_done = 1;
        applyStimulus(s, mk(C_NONE, 1, 13, 3), "md_done");
        s = idle();
        applyStimulus(s, mk(C_NONE, 1, 13, 3), "md_after");
        s = idle(); s.md_start = 1; s.md_done = 1;
        applyStimulus(s, mk(C_NONE, 0, 0, 0), "md_same_cycle");
        s = idle();
        applyStimulus(s, mk(C_NONE, 1, 13, 3), "md_same_after");

        // Watchdog: md_done never comes
        s = idle(); s.md_start = 1;
        applyStimulus(s, mk(C_MD, 0, 0, 0), "wd_start");
        s = idle();
        for (int i = 0; i < 64; i++) begin
            applyStimulus(s, mk(C_MD, 0, 0, 0), "wd_wait");
        end
        applyStimulus(s, mk(C_TO, 1, 78, 3), "wd_fire");
        applyStimulus(s, mk(C_NONE, 1, 78, 3), "wd_back_run");

        // Reset in the middle of MD_WAIT
        s = idle(); s.md_start = 1;
        applyStimulus(s, mk(C_MD, 0, 0, 0), "rst_md_start");
        s = idle();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(s, mk(C_MD, 0, 0, 0), "rst_md_wait");
        end
        s.rst = 1;
        applyStimulus(s, mk(C_RESET, 1, 0, 0), "rst_mid_md");
        applyStimulus(s, mk(C_RESET, 1, 0, 0), "rst_hold");
        s = idle();
        applyStimulus(s, mk(C_NONE, 1, 0, 0), "rst_release");
        applyStimulus(s, mk(C_NONE, 1, 0, 0), "rst_run");

        for (int i = 0; i < 4 && expQ.size() != 0; i++) begin
            @(posedge clk);
        end
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain pending %0d want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
